// File: rtl/wash_seq_ctrl.sv
// Washer program sequencer: coin pricing, per-program phase masks and run-time
// durations, door pause/resume and a remaining-ticks readout. All outputs registered.
module wash_seq_ctrl #(
  parameter int                    NUM_PROG  = 4,
  parameter int                    TW        = 8,
  parameter int                    TICK_DIV  = 190,
  parameter int                    PRICE     = 2,
  parameter int                    CW        = 4,
  parameter logic [4*NUM_PROG-1:0] PROG_MASK = 16'hFFFF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_PROG-1:0]      prog_sel,
  input  logic                     coin,
  input  logic                     start,
  input  logic                     cancel,
  input  logic                     door_open,
  input  logic [NUM_PROG*4*TW-1:0] dur_tbl,
  output logic                     idle,
  output logic                     ready,
  output logic [3:0]               phase,
  output logic                     paused,
  output logic                     done,
  output logic                     error,
  output logic                     coin_rtrn,
  output logic [CW-1:0]            credit,
  output logic [TW-1:0]            remain
);

  localparam int PW  = (NUM_PROG > 1) ? $clog2(NUM_PROG) : 1;
  localparam int PSW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0]  CMAX      = {CW{1'b1}};
  localparam logic [CW-1:0]  PRICE_C   = CW'(PRICE);
  localparam logic [PSW-1:0] TICK_LAST = PSW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PAY   = 3'd1,
    S_READY = 3'd2,
    S_RUN   = 3'd3,
    S_PAUSE = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  state_t         state_r, nxt_state_s;
  logic [CW-1:0]  credit_r, credit_nxt_s, cr_acc_s;
  logic [PW-1:0]  prog_idx_r, prog_nxt_s, sel_idx_s;
  logic [1:0]     ph_idx_r, ph_nxt_s, srch_idx_s;
  logic [TW-1:0]  remain_r, remain_nxt_s, srch_dur_s;
  logic [PSW-1:0] presc_r, presc_nxt_s;
  logic [2:0]     srch_base_s;
  logic           srch_found_s, cr_sat_s, tick_s, sel_zero_s, sel_onehot_s, rtrn_nxt_s;
  logic           idle_r, ready_r, paused_r, done_r, error_r, rtrn_r;
  logic [3:0]     phase_r;

  function automatic logic mask_of(input logic [PW-1:0] p, input logic [1:0] ph);
    return PROG_MASK[int'(p) * 4 + int'(ph)];
  endfunction

  function automatic logic [TW-1:0] dur_of(input logic [PW-1:0] p, input logic [1:0] ph,
                                           input logic [NUM_PROG*4*TW-1:0] tbl);
    return tbl[(int'(p) * 4 + int'(ph)) * TW +: TW];
  endfunction

  assign cr_sat_s     = (credit_r == CMAX);
  assign cr_acc_s     = (coin && !cr_sat_s) ? (credit_r + CW'(1)) : credit_r;
  assign tick_s       = (presc_r == TICK_LAST);
  assign sel_zero_s   = (prog_sel == {NUM_PROG{1'b0}});
  assign sel_onehot_s = $onehot(prog_sel);
  // Search starts at soak when arming, or just past the current phase when advancing.
  assign srch_base_s  = (state_r == S_RUN) ? ({1'b0, ph_idx_r} + 3'd1) : 3'd0;

  // Index of the selected program (meaningful only when prog_sel is one-hot).
  always_comb begin
    sel_idx_s = {PW{1'b0}};
    for (int i = 0; i < NUM_PROG; i++) begin
      if (prog_sel[i]) sel_idx_s = PW'(i);
      else             sel_idx_s = sel_idx_s;
    end
  end

  // First enabled, non-zero-duration phase at or after srch_base_s for the latched program.
  always_comb begin
    srch_found_s = 1'b0;
    srch_idx_s   = 2'd0;
    srch_dur_s   = {TW{1'b0}};
    for (int i = 3; i >= 0; i--) begin
      if ((3'(i) >= srch_base_s) && mask_of(prog_idx_r, 2'(i)) &&
          (dur_of(prog_idx_r, 2'(i), dur_tbl) != {TW{1'b0}})) begin
        srch_found_s = 1'b1;
        srch_idx_s   = 2'(i);
        srch_dur_s   = dur_of(prog_idx_r, 2'(i), dur_tbl);
      end else begin
        srch_found_s = srch_found_s;
      end
    end
  end

  // Next-state, credit, coin return and phase/timer datapath.
  always_comb begin
    nxt_state_s  = state_r;
    credit_nxt_s = credit_r;
    rtrn_nxt_s   = 1'b0;
    prog_nxt_s   = prog_idx_r;
    ph_nxt_s     = ph_idx_r;
    remain_nxt_s = remain_r;
    presc_nxt_s  = presc_r;
    case (state_r)
      S_IDLE: begin
        if (coin) begin
          nxt_state_s  = S_PAY;
          credit_nxt_s = cr_acc_s;
          rtrn_nxt_s   = cr_sat_s;
        end else begin
          nxt_state_s = S_IDLE;
        end
      end
      S_PAY: begin
        if (cancel) begin
          nxt_state_s  = S_IDLE;
          credit_nxt_s = {CW{1'b0}};
          rtrn_nxt_s   = 1'b1;
        end else begin
          credit_nxt_s = cr_acc_s;
          rtrn_nxt_s   = coin && cr_sat_s;
          if ((cr_acc_s < PRICE_C) || sel_zero_s) begin
            nxt_state_s = S_PAY;
          end else if (sel_onehot_s) begin
            nxt_state_s = S_READY;
            prog_nxt_s  = sel_idx_s;
          end else begin
            nxt_state_s  = S_ERR;
            credit_nxt_s = {CW{1'b0}};
            rtrn_nxt_s   = 1'b1;
          end
        end
      end
      S_READY: begin
        if (cancel) begin
          nxt_state_s  = S_IDLE;
          credit_nxt_s = {CW{1'b0}};
          rtrn_nxt_s   = 1'b1;
        end else begin
          rtrn_nxt_s = coin;
          if (start && !door_open) begin
            credit_nxt_s = credit_r - PRICE_C;
            presc_nxt_s  = {PSW{1'b0}};
            if (srch_found_s) begin
              nxt_state_s  = S_RUN;
              ph_nxt_s     = srch_idx_s;
              remain_nxt_s = srch_dur_s;
            end else begin
              nxt_state_s = S_DONE;
            end
          end else begin
            nxt_state_s = S_READY;
          end
        end
      end
      S_RUN: begin
        rtrn_nxt_s = coin;
        if (cancel) begin
          nxt_state_s  = S_IDLE;
          remain_nxt_s = {TW{1'b0}};
          presc_nxt_s  = {PSW{1'b0}};
        end else if (door_open) begin
          nxt_state_s = S_PAUSE;
        end else if (tick_s) begin
          presc_nxt_s = {PSW{1'b0}};
          if (remain_r == TW'(1)) begin
            if (srch_found_s) begin
              ph_nxt_s     = srch_idx_s;
              remain_nxt_s = srch_dur_s;
            end else begin
              nxt_state_s  = S_DONE;
              remain_nxt_s = {TW{1'b0}};
            end
          end else begin
            remain_nxt_s = remain_r - TW'(1);
          end
        end else begin
          presc_nxt_s = presc_r + PSW'(1);
        end
      end
      S_PAUSE: begin
        rtrn_nxt_s = coin;
        if (cancel) begin
          nxt_state_s  = S_IDLE;
          remain_nxt_s = {TW{1'b0}};
          presc_nxt_s  = {PSW{1'b0}};
        end else if (!door_open) begin
          nxt_state_s = S_RUN;
        end else begin
          nxt_state_s = S_PAUSE;
        end
      end
      S_DONE: begin
        rtrn_nxt_s = coin;
        if (cancel || (credit_r == {CW{1'b0}})) nxt_state_s = S_IDLE;
        else                                    nxt_state_s = S_PAY;
      end
      S_ERR: begin
        rtrn_nxt_s = coin;
        if (cancel) nxt_state_s = S_IDLE;
        else        nxt_state_s = S_ERR;
      end
      default: begin
        nxt_state_s  = S_IDLE;
        credit_nxt_s = {CW{1'b0}};
        remain_nxt_s = {TW{1'b0}};
        presc_nxt_s  = {PSW{1'b0}};
      end
    endcase
  end

  // State, datapath and registered outputs; outputs are decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= S_IDLE;
      credit_r   <= {CW{1'b0}};
      prog_idx_r <= {PW{1'b0}};
      ph_idx_r   <= 2'd0;
      remain_r   <= {TW{1'b0}};
      presc_r    <= {PSW{1'b0}};
      idle_r     <= 1'b1;
      ready_r    <= 1'b0;
      paused_r   <= 1'b0;
      done_r     <= 1'b0;
      error_r    <= 1'b0;
      rtrn_r     <= 1'b0;
      phase_r    <= 4'b0000;
    end else begin
      state_r    <= nxt_state_s;
      credit_r   <= credit_nxt_s;
      prog_idx_r <= prog_nxt_s;
      ph_idx_r   <= ph_nxt_s;
      remain_r   <= remain_nxt_s;
      presc_r    <= presc_nxt_s;
      idle_r     <= (nxt_state_s == S_IDLE) || (nxt_state_s == S_PAY);
      ready_r    <= (nxt_state_s == S_READY);
      paused_r   <= (nxt_state_s == S_PAUSE);
      done_r     <= (nxt_state_s == S_DONE);
      error_r    <= (nxt_state_s == S_ERR);
      rtrn_r     <= rtrn_nxt_s;
      phase_r    <= ((nxt_state_s == S_RUN) || (nxt_state_s == S_PAUSE)) ?
                    (4'b0001 << ph_nxt_s) : 4'b0000;
    end
  end

  assign idle      = idle_r;
  assign ready     = ready_r;
  assign phase     = phase_r;
  assign paused    = paused_r;
  assign done      = done_r;
  assign error     = error_r;
  assign coin_rtrn = rtrn_r;
  assign credit    = credit_r;
  assign remain    = remain_r;

endmodule

// File: tb/tb_wash_seq_ctrl.sv
// Self-checking bench for wash_seq_ctrl: directed scenarios plus randomized programs,
// durations, door pauses and stray coins, checked against a cycle timeline model.
module tb_wash_seq_ctrl;
  localparam int NUM_PROG = 4;
  localparam int TW       = 8;
  localparam int TICK_DIV = 3;
  localparam int PRICE    = 2;
  localparam int CW       = 4;
  // prog0 {spin,wash}, prog1 all, prog2 none, prog3 {rinse,soak}
  localparam logic [15:0] PROG_MASK = 16'h50FA;

  typedef struct {
    logic [3:0]    ph;
    logic [TW-1:0] rem;
    logic          pz;
    logic          door;
  } exp_t;

  logic clk = 1'b0;
  logic rst, coin, start, cancel, door_open;
  logic [NUM_PROG-1:0] prog_sel;
  logic [NUM_PROG*4*TW-1:0] dur_tbl;
  logic idle, ready, paused, done, error, coin_rtrn;
  logic [3:0] phase;
  logic [CW-1:0] credit;
  logic [TW-1:0] remain;
  int checks = 0;
  int errors = 0;

  wash_seq_ctrl #(.NUM_PROG(NUM_PROG), .TW(TW), .TICK_DIV(TICK_DIV), .PRICE(PRICE),
                  .CW(CW), .PROG_MASK(PROG_MASK)) dut (
    .clk(clk), .rst(rst), .prog_sel(prog_sel), .coin(coin), .start(start),
    .cancel(cancel), .door_open(door_open), .dur_tbl(dur_tbl), .idle(idle),
    .ready(ready), .phase(phase), .paused(paused), .done(done), .error(error),
    .coin_rtrn(coin_rtrn), .credit(credit), .remain(remain));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    coin   = 1'b0;
    start  = 1'b0;
    cancel = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if ({idle, ready, phase, paused, done, error, coin_rtrn, credit, remain} !==
        {1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0}) begin
      errors++;
      $display("FAIL reset: got idle=%b rdy=%b ph=%b pz=%b done=%b err=%b rtrn=%b cr=%0d rem=%0d, want idle=1 rest 0",
               idle, ready, phase, paused, done, error, coin_rtrn, credit, remain);
    end
    rst = 1'b0;
  endtask

  // Coins up to PRICE with program p selected, then start; the bench timeline model is
  // built from the phase rules: each enabled non-zero phase shows remain=d..1, TICK_DIV cycles each.
  task automatic run_prog(input int p, input int d0, input int d1, input int d2, input int d3,
                          input int pk, input int pl, input bit stray);
    int d[4];
    exp_t s[$];
    exp_t q[$];
    exp_t e;
    logic prev_coin;
    int k;
    d = '{d0, d1, d2, d3};
    for (int ph = 0; ph < 4; ph++) dur_tbl[(p * 4 + ph) * TW +: TW] = TW'(d[ph]);
    prog_sel = NUM_PROG'(1 << p);
    coin = 1'b1; step();
    coin = 1'b1; step();
    checks++;
    if ({ready, credit} !== {1'b1, 4'(PRICE)}) begin
      errors++;
      $display("FAIL arm p%0d: got ready=%b credit=%0d, want 1/%0d", p, ready, credit, PRICE);
    end
    prog_sel = NUM_PROG'($urandom);
    for (int ph = 0; ph < 4; ph++)
      if (PROG_MASK[p * 4 + ph] && d[ph] != 0)
        for (int r = d[ph]; r >= 1; r--)
          for (int t = 0; t < TICK_DIV; t++) begin
            e.ph = 4'(1 << ph); e.rem = TW'(r); e.pz = 1'b0; e.door = 1'b0;
            s.push_back(e);
          end
    if (pl > 0 && s.size() > 0) begin
      k = pk % s.size();
      for (int j = 0; j <= k; j++) q.push_back(s[j]);
      q[k].door = 1'b1;
      for (int m = 1; m <= pl; m++) begin
        e = s[k]; e.pz = 1'b1; e.door = (m < pl);
        q.push_back(e);
      end
      q.push_back(s[k]);
      for (int j = k + 1; j < s.size(); j++) q.push_back(s[j]);
    end else begin
      q = s;
    end
    start = 1'b1;
    step();
    prev_coin = 1'b0;
    foreach (q[j]) begin
      checks++;
      if ({phase, remain, paused, done, ready, idle, coin_rtrn} !==
          {q[j].ph, q[j].rem, q[j].pz, 1'b0, 1'b0, 1'b0, prev_coin}) begin
        errors++;
        $display("FAIL run p%0d cyc%0d: got ph=%b rem=%0d pz=%b done=%b rdy=%b idle=%b rtrn=%b, want ph=%b rem=%0d pz=%b rtrn=%b",
                 p, j, phase, remain, paused, done, ready, idle, coin_rtrn,
                 q[j].ph, q[j].rem, q[j].pz, prev_coin);
      end
      door_open = q[j].door;
      prev_coin = stray && ($urandom_range(0, 7) == 0);
      coin = prev_coin;
      step();
    end
    door_open = 1'b0;
    checks++;
    if ({done, phase, remain, credit, idle, coin_rtrn} !== {1'b1, 4'b0000, 8'd0, 4'd0, 1'b0, prev_coin}) begin
      errors++;
      $display("FAIL done p%0d: got done=%b ph=%b rem=%0d cr=%0d idle=%b rtrn=%b, want 1/0/0/0/0/%b",
               p, done, phase, remain, credit, idle, coin_rtrn, prev_coin);
    end
    step();
    checks++;
    if ({idle, done} !== 2'b10) begin
      errors++;
      $display("FAIL after-done p%0d: got idle=%b done=%b, want idle=1 done=0", p, idle, done);
    end
  endtask

  task automatic test_cancel_pay();
    prog_sel = 4'b0001;
    coin = 1'b1; step();
    checks++;
    if ({idle, credit} !== {1'b1, 4'd1}) begin
      errors++;
      $display("FAIL pay-coin: got idle=%b credit=%0d, want 1/1", idle, credit);
    end
    cancel = 1'b1; step();
    checks++;
    if ({coin_rtrn, credit, idle} !== {1'b1, 4'd0, 1'b1}) begin
      errors++;
      $display("FAIL pay-cancel: got rtrn=%b credit=%0d idle=%b, want 1/0/1", coin_rtrn, credit, idle);
    end
    step();
    checks++;
    if (coin_rtrn !== 1'b0) begin
      errors++;
      $display("FAIL pay-cancel-pulse: got rtrn=%b, want 0", coin_rtrn);
    end
  endtask

  task automatic test_multi_hot();
    prog_sel = 4'b0110;
    coin = 1'b1; step();
    coin = 1'b1; step();
    checks++;
    if ({error, coin_rtrn, credit, idle} !== {1'b1, 1'b1, 4'd0, 1'b0}) begin
      errors++;
      $display("FAIL multi-hot: got err=%b rtrn=%b cr=%0d idle=%b, want 1/1/0/0", error, coin_rtrn, credit, idle);
    end
    step();
    checks++;
    if ({error, coin_rtrn} !== 2'b10) begin
      errors++;
      $display("FAIL err-hold: got err=%b rtrn=%b, want 1/0", error, coin_rtrn);
    end
    cancel = 1'b1; step();
    checks++;
    if ({error, idle} !== 2'b01) begin
      errors++;
      $display("FAIL err-cancel: got err=%b idle=%b, want 0/1", error, idle);
    end
  endtask

  task automatic test_ready_guards();
    prog_sel = 4'b0000;
    coin = 1'b1; step();
    coin = 1'b1; step();
    step();
    checks++;
    if ({idle, ready, credit} !== {1'b1, 1'b0, 4'd2}) begin
      errors++;
      $display("FAIL pay-wait: got idle=%b rdy=%b cr=%0d, want 1/0/2", idle, ready, credit);
    end
    prog_sel = 4'b0010; step();
    checks++;
    if ({ready, idle} !== 2'b10) begin
      errors++;
      $display("FAIL pay-select: got rdy=%b idle=%b, want 1/0", ready, idle);
    end
    coin = 1'b1; step();
    checks++;
    if ({ready, coin_rtrn, credit} !== {1'b1, 1'b1, 4'd2}) begin
      errors++;
      $display("FAIL ready-coin: got rdy=%b rtrn=%b cr=%0d, want 1/1/2", ready, coin_rtrn, credit);
    end
    door_open = 1'b1; start = 1'b1; step();
    door_open = 1'b0;
    checks++;
    if ({ready, phase, credit, coin_rtrn} !== {1'b1, 4'b0000, 4'd2, 1'b0}) begin
      errors++;
      $display("FAIL start-door: got rdy=%b ph=%b cr=%0d rtrn=%b, want 1/0/2/0", ready, phase, credit, coin_rtrn);
    end
    coin = 1'b1; cancel = 1'b1; step();
    checks++;
    if ({coin_rtrn, idle, ready, credit} !== {1'b1, 1'b1, 1'b0, 4'd0}) begin
      errors++;
      $display("FAIL coin+cancel: got rtrn=%b idle=%b rdy=%b cr=%0d, want 1/1/0/0", coin_rtrn, idle, ready, credit);
    end
    step();
    checks++;
    if (coin_rtrn !== 1'b0) begin
      errors++;
      $display("FAIL coin+cancel-pulse: got rtrn=%b, want 0", coin_rtrn);
    end
  endtask

  task automatic test_saturation();
    dur_tbl[(1 * 4 + 0) * TW +: TW] = 8'd4;
    prog_sel = 4'b0000;
    repeat (15) begin coin = 1'b1; step(); end
    checks++;
    if ({credit, idle, coin_rtrn} !== {4'd15, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL sat-fill: got cr=%0d idle=%b rtrn=%b, want 15/1/0", credit, idle, coin_rtrn);
    end
    coin = 1'b1; step();
    checks++;
    if ({credit, coin_rtrn} !== {4'd15, 1'b1}) begin
      errors++;
      $display("FAIL sat-coin: got cr=%0d rtrn=%b, want 15/1", credit, coin_rtrn);
    end
    prog_sel = 4'b0010; step();
    start = 1'b1; step();
    checks++;
    if ({phase, remain, credit} !== {4'b0001, 8'd4, 4'd13}) begin
      errors++;
      $display("FAIL sat-start: got ph=%b rem=%0d cr=%0d, want 0001/4/13", phase, remain, credit);
    end
    step(); step();
    cancel = 1'b1; step();
    checks++;
    if ({idle, credit, coin_rtrn, phase, remain} !== {1'b1, 4'd13, 1'b0, 4'b0000, 8'd0}) begin
      errors++;
      $display("FAIL run-cancel: got idle=%b cr=%0d rtrn=%b ph=%b rem=%0d, want 1/13/0/0/0",
               idle, credit, coin_rtrn, phase, remain);
    end
    prog_sel = 4'b0100;
    coin = 1'b1; step();
    step();
    checks++;
    if ({ready, credit} !== {1'b1, 4'd14}) begin
      errors++;
      $display("FAIL rearm: got rdy=%b cr=%0d, want 1/14", ready, credit);
    end
    start = 1'b1; step();
    checks++;
    if ({done, phase, credit} !== {1'b1, 4'b0000, 4'd12}) begin
      errors++;
      $display("FAIL empty-prog: got done=%b ph=%b cr=%0d, want 1/0/12", done, phase, credit);
    end
    step();
    checks++;
    if ({idle, done, credit} !== {1'b1, 1'b0, 4'd12}) begin
      errors++;
      $display("FAIL done-to-pay: got idle=%b done=%b cr=%0d, want 1/0/12", idle, done, credit);
    end
    step();
    cancel = 1'b1; step();
    checks++;
    if ({coin_rtrn, credit, idle} !== {1'b1, 4'd0, 1'b1}) begin
      errors++;
      $display("FAIL final-cancel: got rtrn=%b cr=%0d idle=%b, want 1/0/1", coin_rtrn, credit, idle);
    end
  endtask

  task automatic test_rst_mid_run();
    dur_tbl[(1 * 4 + 1) * TW +: TW] = 8'd6;
    prog_sel = 4'b0010;
    coin = 1'b1; step();
    coin = 1'b1; step();
    start = 1'b1; step();
    repeat (5) step();
    rst = 1'b1; step();
    rst = 1'b0;
    checks++;
    if ({idle, ready, phase, paused, done, error, coin_rtrn, credit, remain} !==
        {1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0}) begin
      errors++;
      $display("FAIL rst-mid-run: got idle=%b ph=%b rem=%0d cr=%0d, want idle=1 rest 0", idle, phase, remain, credit);
    end
  endtask

  task automatic test_random();
    int dd[4];
    for (int it = 0; it < 16; it++) begin
      for (int i = 0; i < 4; i++) dd[i] = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 5);
      run_prog($urandom_range(0, 3), dd[0], dd[1], dd[2], dd[3], $urandom_range(0, 60),
               ($urandom_range(0, 1) == 1) ? $urandom_range(1, 5) : 0, 1'b1);
    end
  endtask

  initial begin
    rst = 1'b1; coin = 1'b0; start = 1'b0; cancel = 1'b0; door_open = 1'b0;
    prog_sel = '0; dur_tbl = '0;
    test_reset();
    run_prog(1, 3, 2, 1, 4, 0, 0, 1'b0);
    run_prog(0, 5, 3, 2, 2, 0, 0, 1'b0);
    run_prog(0, 5, 0, 2, 2, 0, 0, 1'b0);
    run_prog(1, 3, 2, 1, 4, 9, 7, 1'b0);
    test_cancel_pay();
    test_multi_hot();
    test_ready_guards();
    test_saturation();
    test_rst_mid_run();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
